// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
//   Shares one sequential GCD core (load/done handshake) among NREQ
//   requesters. Jobs are taken round-robin, one at a time. Operand pairs
//   with a zero skip the core. A watchdog aborts a core job that never
//   completes.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid_i      per-requester job request, held until accepted
//   req_ready_o      one-hot accept, only in the IDLE cycle that grants
//   req_a_i/req_b_i  operands, requester i at [i*W +: W]
//   rsp_valid_o      one-hot result valid for the granted requester
//   rsp_ready_i      per-requester result accept; only the grantee's bit is used
//   rsp_data_o       GCD result, shared by all requesters
//   rsp_err_o        1 = job aborted by the watchdog
//   core_load_o      one-cycle load pulse, with operands on core_a_o/core_b_o
//   core_clr_o       one-cycle abort pulse to the core
//   core_done_i      core completion pulse, core_result_i valid that cycle
//   busy_o           scheduler is not IDLE
//   grant_id_o       index of the current or last granted requester
module gcd_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = 256,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [W-1:0]      rsp_data_o,
  output logic              rsp_err_o,
  output logic              core_load_o,
  output logic [W-1:0]      core_a_o,
  output logic [W-1:0]      core_b_o,
  output logic              core_clr_o,
  input  logic              core_done_i,
  input  logic [W-1:0]      core_result_i,
  output logic              busy_o,
  output logic [IDW-1:0]    grant_id_o
);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         core_a_q, core_a_d;
  logic [W-1:0]         core_b_q, core_b_d;
  logic                 core_load_q, core_load_d;
  logic                 core_clr_q, core_clr_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [W-1:0]         data_q, data_d;
  logic                 err_q, err_d;

  // Per-requester view of the flat operand buses.
  logic [NREQ-1:0][W-1:0] req_a, req_b;
  assign req_a = req_a_i;
  assign req_b = req_b_i;

  // Round-robin winner: first valid requester after last_q, with wrap.
  logic [IDW-1:0]  win;
  logic            found;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] gnt_oh;
  logic [W-1:0]    op_a, op_b;

  always_comb begin
    int j;
    logic [IDW-1:0] idx;
    win   = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IDW'(j);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = found;
    gnt_oh          = '0;
    gnt_oh[grant_q] = 1'b1;
  end

  assign op_a = req_a[win];
  assign op_b = req_b[win];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_load_d = 1'b0;
    core_clr_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          if (op_a == '0 || op_b == '0) begin
            // gcd(x,0) = x, and gcd(0,0) is reported as 0.
            data_d      = op_a | op_b;
            err_d       = 1'b0;
            rsp_valid_d = win_oh;
            state_d     = RESP;
          end else begin
            // Operands go to the core register here so they are already
            // on core_a_o/core_b_o while the load pulse is high.
            core_a_d    = op_a;
            core_b_d    = op_b;
            core_load_d = 1'b1;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // Done is checked first so a completion on the last allowed
        // cycle is returned as a good result, not aborted.
        if (core_done_i) begin
          data_d      = core_result_i;
          err_d       = 1'b0;
          rsp_valid_d = gnt_oh;
          state_d     = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          core_clr_d  = 1'b1;
          data_d      = '0;
          err_d       = 1'b1;
          rsp_valid_d = gnt_oh;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Aborted jobs still count as served for fairness.
        if (rsp_ready_i[grant_q]) begin
          rsp_valid_d = '0;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_load_q <= 1'b0;
      core_clr_q  <= 1'b0;
      rsp_valid_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_load_q <= core_load_d;
      core_clr_q  <= core_clr_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Ready is the only combinational output: the accept must be seen in
  // the same cycle the request wins.
  assign req_ready_o = (state_q == IDLE) ? win_oh : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign core_load_o = core_load_q;
  assign core_a_o    = core_a_q;
  assign core_b_o    = core_b_q;
  assign core_clr_o  = core_clr_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
module tb_gcd_job_scheduler;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a = '0;
  logic [1:0][31:0] req_b = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             core_load;
  logic [31:0]      core_a, core_b;
  logic             core_clr;
  logic             core_done = 1'b0;
  logic [31:0]      core_result = '0;
  logic             busy;
  logic             grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_job_scheduler #(.NREQ(2), .W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .core_load_o(core_load), .core_a_o(core_a), .core_b_o(core_b),
    .core_clr_o(core_clr), .core_done_i(core_done), .core_result_i(core_result),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %0d/%b exp 0/0", rsp_data, rsp_err); end
    n_checks++; if (core_load !== 1'b0 || core_clr !== 1'b0) begin n_fail++; $display("FAIL reset_core_ctl got %b%b exp 00", core_load, core_clr); end
    n_checks++; if (core_a !== 32'd0 || core_b !== 32'd0) begin n_fail++; $display("FAIL reset_core_ops got %0d/%0d exp 0/0", core_a, core_b); end
    n_checks++; if (busy !== 1'b0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_busy_grant got %b/%b exp 0/0", busy, grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_a[0] = 48; req_b[0] = 18; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b exp 01", req_ready); end
    step(); req_valid = 2'b00;
    n_checks++; if (core_load !== 1'b1 || core_a !== 32'd48 || core_b !== 32'd18) begin n_fail++; $display("FAIL single_load got %b %0d %0d exp 1 48 18", core_load, core_a, core_b); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    step();
    n_checks++; if (core_load !== 1'b0) begin n_fail++; $display("FAIL single_load_pulse got %b exp 0", core_load); end
    step();
    step();
    core_done = 1'b1; core_result = 6;
    step(); core_done = 1'b0; core_result = 0;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd6 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp got %b %0d %b exp 01 6 0", rsp_valid, rsp_data, rsp_err); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd6) begin n_fail++; $display("FAIL single_hold got %b %0d exp 01 6", rsp_valid, rsp_data); end
    end
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done got %b %b exp 00 0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic       exp_id;
    logic [1:0] exp_oh;
    logic [31:0] exp_d;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_a[0] = 0; req_b[0] = 5; req_a[1] = 0; req_b[1] = 7;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_id = 1'(i % 2);
      exp_oh = exp_id ? 2'b10 : 2'b01;
      exp_d  = exp_id ? 32'd7 : 32'd5;
      #1;
      n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready, exp_oh); end
      step();
      n_checks++; if (grant_id !== exp_id || rsp_valid !== exp_oh || rsp_data !== exp_d) begin n_fail++; $display("FAIL rr_rsp[%0d] got %b %b %0d exp %b %b %0d", i, grant_id, rsp_valid, rsp_data, exp_id, exp_oh, exp_d); end
      rsp_ready = exp_oh; step(); rsp_ready = 2'b00;
    end
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      req_b[1] = 32'(100 + i);
      #1;
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL solo1_ready[%0d] got %b exp 10", i, req_ready); end
      step();
      n_checks++; if (grant_id !== 1'b1 || rsp_data !== 32'(100 + i)) begin n_fail++; $display("FAIL solo1_rsp[%0d] got %b %0d exp 1 %0d", i, grant_id, rsp_data, 100 + i); end
      rsp_ready = 2'b10; step(); rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_bypass();
    req_a[0] = 0; req_b[0] = 35; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL byp_ready got %b exp 01", req_ready); end
    step(); req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd35 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL byp_rsp got %b %0d %b exp 01 35 0", rsp_valid, rsp_data, rsp_err); end
    n_checks++; if (core_load !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL byp_noload got %b %b exp 0 1", core_load, busy); end
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    n_checks++; if (core_load !== 1'b0) begin n_fail++; $display("FAIL byp_noload2 got %b exp 0", core_load); end
    req_a[0] = 0; req_b[0] = 0; req_valid = 2'b01;
    step(); req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || core_load !== 1'b0) begin n_fail++; $display("FAIL byp_zero got %b %0d %b exp 01 0 0", rsp_valid, rsp_data, core_load); end
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    req_a[1] = 12; req_b[1] = 0; req_valid = 2'b10;
    step(); req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd12 || core_load !== 1'b0) begin n_fail++; $display("FAIL byp_bzero got %b %0d %b exp 10 12 0", rsp_valid, rsp_data, core_load); end
    rsp_ready = 2'b10; step(); rsp_ready = 2'b00;
  endtask

  task automatic test_watchdog();
    for (int v = 0; v < 2; v++) begin
      req_a[0] = 9; req_b[0] = 6; req_valid = 2'b01;
      step(); req_valid = 2'b00;   // LOAD
      step();                      // BUSY cycle 0
      for (int c = 1; c < 8; c++) begin
        step();
        n_checks++; if (core_clr !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wd%0d_busy[%0d] got %b %b exp 0 00", v, c, core_clr, rsp_valid); end
      end
      if (v == 1) begin core_done = 1'b1; core_result = 3; end
      step(); core_done = 1'b0; core_result = 0;
      if (v == 0) begin
        n_checks++; if (core_clr !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wd_abort got %b %b %0d %b exp 1 1 0 01", core_clr, rsp_err, rsp_data, rsp_valid); end
      end else begin
        n_checks++; if (core_clr !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd3 || rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wd_done_wins got %b %b %0d %b exp 0 0 3 01", core_clr, rsp_err, rsp_data, rsp_valid); end
      end
      core_done = 1'b1; core_result = 99;
      step(); core_done = 1'b0; core_result = 0;
      n_checks++; if (core_clr !== 1'b0) begin n_fail++; $display("FAIL wd%0d_clr_once got %b exp 0", v, core_clr); end
      n_checks++; if (rsp_data !== (v == 0 ? 32'd0 : 32'd3) || rsp_err !== (v == 0)) begin n_fail++; $display("FAIL wd%0d_ignore_done got %0d %b", v, rsp_data, rsp_err); end
      rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    req_a[0] = 0; req_b[0] = 21; req_valid = 2'b01;
    step();
    req_a[1] = 0; req_b[1] = 44; req_valid = 2'b10;
    rsp_ready = 2'b10;   // not the grantee: must be ignored
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd21 || req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %b %0d %b %b exp 01 21 00 1", i, rsp_valid, rsp_data, req_ready, busy); end
      step();
    end
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_ready got %b exp 10", req_ready); end
    step(); req_valid = 2'b00;
    n_checks++; if (grant_id !== 1'b1 || rsp_valid !== 2'b10 || rsp_data !== 32'd44) begin n_fail++; $display("FAIL bp_next_rsp got %b %b %0d exp 1 10 44", grant_id, rsp_valid, rsp_data); end
    rsp_ready = 2'b10; step(); rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    // Serve requester 0 first so that, without reset, requester 1 would be next.
    req_a[0] = 0; req_b[0] = 1; req_valid = 2'b01;
    step(); req_valid = 2'b00;
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    req_a[0] = 48; req_b[0] = 18; req_valid = 2'b01;
    step(); req_valid = 2'b00;   // LOAD
    step(); step();              // BUSY
    #2; rst_n = 1'b0; #1;
    n_checks++; if (busy !== 1'b0 || core_load !== 1'b0 || core_clr !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rstmid_ctl got %b %b %b %b %b exp all 0", busy, core_load, core_clr, rsp_valid, req_ready); end
    n_checks++; if (core_a !== 32'd0 || core_b !== 32'd0 || rsp_data !== 32'd0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL rstmid_data got %0d %0d %0d %b exp 0 0 0 0", core_a, core_b, rsp_data, grant_id); end
    rst_n = 1'b1;
    req_a[0] = 0; req_b[0] = 10; req_a[1] = 0; req_b[1] = 20; req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_prio got %b exp 01", req_ready); end
    step(); req_valid = 2'b00;
    n_checks++; if (grant_id !== 1'b0 || rsp_data !== 32'd10 || rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rstmid_rsp got %b %0d %b exp 0 10 01", grant_id, rsp_data, rsp_valid); end
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_bypass();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
- Shares one sequential GCD core (load/done style datapath) among NREQ requesters, e.g. Wishbone-mapped firmware and the logic-analyser path.
- Accepts operand pairs over per-requester valid/ready, arbitrates round-robin, sequences the core through load and wait, then returns the result to the winning requester.
- Bypasses the core for trivial operands and aborts hung jobs with a watchdog.
- Sits between the bus/LA front ends and the GCD core inside the user project.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width.
- TIMEOUT, 256, max core cycles per job before abort (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  NREQ  per-requester job request; held until accepted
- req_ready_o  out  NREQ  one-hot job accept
- req_a_i  in  NREQ*W  operand A, requester i at [i*W +: W]
- req_b_i  in  NREQ*W  operand B, same packing
- rsp_valid_o  out  NREQ  one-hot result valid
- rsp_ready_i  in  NREQ  result accept
- rsp_data_o  out  W  GCD result, shared by all requesters
- rsp_err_o  out  1  1 = job aborted by watchdog
- core_load_o  out  1  one-cycle load pulse to core
- core_a_o  out  W  operand A to core
- core_b_o  out  W  operand B to core
- core_clr_o  out  1  one-cycle core abort/clear pulse
- core_done_i  in  1  core completion pulse; core_result_i valid that cycle
- core_result_i  in  W  core result
- busy_o  out  1  high in any state except IDLE
- grant_id_o  out  $clog2(NREQ) (min 1)  index of current/last granted requester

Behaviour:
- Reset values:
  - State: IDLE.
  - All outputs 0, including rsp_data_o and core_a_o/core_b_o.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Watchdog counter 0.
- States: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - Winner g is the first i with req_valid_i[i] set, scanning from (last+1) mod NREQ upward with wrap.
  - req_ready_o[g]=1 combinationally in the same cycle; this is the only cycle ready is asserted.
  - On that edge: latch a=req_a_i[g], b=req_b_i[g] and set grant_id_o=g.
  - If a==0 or b==0: bypass the core. Result = a|b (0 when both are 0), err=0, go to RESP.
  - Otherwise go to LOAD.
  - No requests: stay in IDLE.
- LOAD:
  - core_load_o=1 for exactly one cycle, with core_a_o/core_b_o = latched operands.
  - core_a_o/core_b_o hold their values until the next LOAD.
  - Clear the counter, go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - If core_done_i: capture core_result_i into rsp_data_o, err=0, go to RESP.
  - Else if counter==TIMEOUT-1: core_clr_o=1 for one cycle, rsp_data_o=0, err=1, go to RESP.
  - If core_done_i coincides with the timeout cycle, done wins: no clr pulse, err=0.
- RESP:
  - rsp_valid_o[g]=1; rsp_data_o and rsp_err_o stable.
  - When rsp_ready_i[g]=1: set last=g, go to IDLE. The next grant can occur in the cycle immediately after.
  - rsp_ready_i of other requesters is ignored.
- Latency:
  - Bypass job: request-accept edge to rsp_valid = 1 cycle.
  - Core job: accept -> LOAD (1) -> BUSY; rsp_valid appears the cycle after core_done_i.
- Single job in flight; further requests wait with ready low (no queueing).
- core_done_i outside BUSY is ignored.
- req_valid_i dropping before acceptance is legal; the requester simply loses its slot.
- Asynchronous reset mid-job:
  - Returns to IDLE and drops all valid/ready/load/clr outputs immediately.
  - The core shares rst_n, so no clr pulse is needed.
- last updates only on response completion; an aborted (err) job still counts as served.

Test Plan:
- Single requester 0: a=48, b=18 -> one core_load_o pulse with 48/18; model core done after 3 cycles with result 6 -> rsp_valid_o=01, rsp_data_o=6, err=0; held until rsp_ready_i.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1; with req1 only, repeated jobs all go to 1.
- Bypass: a=0, b=35 -> rsp 35 one cycle after accept, core_load_o never pulses; a=0, b=0 -> rsp 0.
- Watchdog: TIMEOUT=8, core never signals done -> core_clr_o pulses once 8 cycles after entering BUSY, rsp_err_o=1, rsp_data_o=0. Repeat with done arriving on cycle 8 -> result returned, no clr.
- Back-pressure: hold rsp_ready_i low 10 cycles while requester 1 waits -> rsp_data_o stable, req_ready_o stays 0, busy_o=1; grant to 1 occurs the cycle after release.
- Reset mid-BUSY: assert rst_n low -> all outputs 0 asynchronously; after release, requester 0 wins first.
